// File: rtl/alu_seq_sliced.sv
// Multi-cycle sliced 74181-style ALU: evaluates 4*SLICES_PER_CYCLE bits per clock with a
// registered ripple carry, valid/ready handshakes and a sticky carry flag for chained ops.
module alu_seq_sliced #(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             use_flag_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             carry_out,
    output logic             zero,
    output logic             negative
);

    localparam int CW    = 4 * SLICES_PER_CYCLE;
    localparam int N     = WIDTH / CW;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_mode;
    logic [3:0]       r_sel;
    logic             r_carry;
    logic             r_flag;
    logic [CNT_W-1:0] r_cnt;
    logic [CW:0]      w_chunk;
    logic             w_cout_eff;
    logic [WIDTH-1:0] w_acc_next;

    // 74181 chunk: X/Y are the generate/propagate-style operand terms; arithmetic adds them,
    // logic mode is the carry-free XNOR of the same terms. Returns {carry, result}.
    function automatic logic [CW:0] chunk_eval(
        input logic [3:0]    s,
        input logic          m,
        input logic [CW-1:0] ca,
        input logic [CW-1:0] cb,
        input logic          c
    );
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW:0]   sum;
        x   = ca | (cb & {CW{s[0]}}) | (~cb & {CW{s[1]}});
        y   = (ca & ~cb & {CW{s[2]}}) | (ca & cb & {CW{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
        chunk_eval = m ? {1'b0, ~(x ^ y)} : sum;
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    // Current chunk evaluation and the accumulator after shifting it in at the top
    always_comb begin
        w_chunk    = chunk_eval(r_sel, r_mode, r_a[CW-1:0], r_b[CW-1:0], r_carry);
        w_cout_eff = r_mode ? 1'b0 : w_chunk[CW];
        w_acc_next = (r_acc >> CW) | (WIDTH'(w_chunk[CW-1:0]) << (WIDTH - CW));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  w_state_n = in_valid ? S_RUN : S_IDLE;
            S_RUN:   w_state_n = (r_cnt == LAST) ? S_DONE : S_RUN;
            S_DONE:  w_state_n = out_ready ? S_IDLE : S_DONE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Operand capture, chunk sequencing and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_acc     <= {WIDTH{1'b0}};
            r_mode    <= 1'b0;
            r_sel     <= 4'd0;
            r_carry   <= 1'b0;
            r_flag    <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            f         <= {WIDTH{1'b0}};
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_mode  <= mode;
                        r_sel   <= sel;
                        r_carry <= use_flag_carry ? r_flag : carry_in;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_acc   <= {WIDTH{1'b0}};
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> CW;
                    r_b     <= r_b >> CW;
                    r_acc   <= w_acc_next;
                    r_carry <= w_chunk[CW];
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        f         <= w_acc_next;
                        carry_out <= w_cout_eff;
                        zero      <= (w_acc_next == {WIDTH{1'b0}});
                        negative  <= w_acc_next[WIDTH-1];
                        r_flag    <= w_cout_eff;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_sliced.sv
// Randomised and directed bench for alu_seq_sliced; one instance per slice setting
// (1 and 4 slices per clock) driven from shared operand buses.
module tb_alu_seq_sliced;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        use_flag_carry;
    logic        iv0, iv1, or0, or1;
    logic        ir0, ir1, ov0, ov1;
    logic [15:0] f0, f1;
    logic        c0, c1, z0, z1, n0, n1;

    int checks = 0;
    int errors = 0;
    bit flag_m[2];

    always #5 clk = ~clk;

    alu_seq_sliced #(.WIDTH(16), .SLICES_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .mode(mode), .sel(sel),
        .a(a), .b(b), .carry_in(carry_in), .use_flag_carry(use_flag_carry),
        .out_valid(ov0), .out_ready(or0), .f(f0), .carry_out(c0), .zero(z0), .negative(n0)
    );

    alu_seq_sliced #(.WIDTH(16), .SLICES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .mode(mode), .sel(sel),
        .a(a), .b(b), .carry_in(carry_in), .use_flag_carry(use_flag_carry),
        .out_valid(ov1), .out_ready(or1), .f(f1), .carry_out(c1), .zero(z1), .negative(n1)
    );

    // Reference: the 74181 function table written as plain integer arithmetic.
    // "minus" entries report carry as no-borrow (result >= 0).
    function automatic logic [16:0] ref_op(input logic m, input logic [3:0] s,
                                           input logic [15:0] aa, input logic [15:0] bb,
                                           input logic c);
        int A, B, NB, ci, r;
        bit minus;
        logic [15:0] nb;
        logic [15:0] lf;
        nb = ~bb;
        A = int'(aa); B = int'(bb); NB = int'(nb); ci = c ? 1 : 0;
        minus = 1'b0;
        if (m) begin
            case (s)
                4'd0:  lf = ~aa;
                4'd1:  lf = ~(aa | bb);
                4'd2:  lf = ~aa & bb;
                4'd3:  lf = 16'h0000;
                4'd4:  lf = ~(aa & bb);
                4'd5:  lf = ~bb;
                4'd6:  lf = aa ^ bb;
                4'd7:  lf = aa & ~bb;
                4'd8:  lf = ~aa | bb;
                4'd9:  lf = ~(aa ^ bb);
                4'd10: lf = bb;
                4'd11: lf = aa & bb;
                4'd12: lf = 16'hFFFF;
                4'd13: lf = aa | ~bb;
                4'd14: lf = aa | bb;
                default: lf = aa;
            endcase
            return {1'b0, lf};
        end
        case (s)
            4'd0:  r = A + ci;
            4'd1:  r = (A | B) + ci;
            4'd2:  r = (A | NB) + ci;
            4'd3:  begin r = -1 + ci; minus = 1'b1; end
            4'd4:  r = A + (A & NB) + ci;
            4'd5:  r = (A | B) + (A & NB) + ci;
            4'd6:  begin r = A - B - 1 + ci; minus = 1'b1; end
            4'd7:  begin r = (A & NB) - 1 + ci; minus = 1'b1; end
            4'd8:  r = A + (A & B) + ci;
            4'd9:  r = A + B + ci;
            4'd10: r = (A | NB) + (A & B) + ci;
            4'd11: begin r = (A & B) - 1 + ci; minus = 1'b1; end
            4'd12: r = A + A + ci;
            4'd13: r = (A | B) + A + ci;
            4'd14: r = (A | NB) + A + ci;
            default: begin r = A - 1 + ci; minus = 1'b1; end
        endcase
        return {(minus ? (r >= 0) : (r >= 65536)), r[15:0]};
    endfunction

    // Issue one operation to instance w; optionally consume the result afterwards
    task automatic do_op(input int w, input logic m, input logic [3:0] s,
                         input logic [15:0] aa, input logic [15:0] bb, input logic cin,
                         input logic ufc, input bit accept,
                         output logic [15:0] rf, output logic rc, output logic rz,
                         output logic rn, output int lat);
        @(negedge clk);
        mode = m; sel = s; a = aa; b = bb; carry_in = cin; use_flag_carry = ufc;
        if (w == 0) iv0 = 1'b1; else iv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0; iv1 = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((w == 0) ? ov0 : ov1) break;
        end
        rf = (w == 0) ? f0 : f1;
        rc = (w == 0) ? c0 : c1;
        rz = (w == 0) ? z0 : z1;
        rn = (w == 0) ? n0 : n1;
        if (accept) begin
            if (w == 0) or0 = 1'b1; else or1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            or0 = 1'b0; or1 = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({f0, c0, z0, n0, ov0} !== 20'h0 || {f1, c1, z1, n1, ov1} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h required 0/0",
                     {f0, c0, z0, n0, ov0}, {f1, c1, z1, n1, ov1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ir0 !== 1'b1 || ir1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b%b required 11", ir0, ir1);
        end
        flag_m[0] = 1'b0; flag_m[1] = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] va[8]  = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h0003, 16'hA5A5, 16'hFFFF, 16'h1234, 16'h0000};
        logic [15:0] vb[8]  = '{16'h0001, 16'h0001, 16'h0000, 16'h0005, 16'hA5A5, 16'hFFFF, 16'h0F0F, 16'h0000};
        logic [3:0]  vs[8]  = '{4'd9, 4'd9, 4'd9, 4'd6, 4'd6, 4'd9, 4'd15, 4'd9};
        logic        vm[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vc[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        vu[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ef[8]  = '{16'h0100, 16'h0000, 16'h0001, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h1234, 16'h0000};
        logic [2:0]  ecz[8] = '{3'b000, 3'b110, 3'b000, 3'b001, 3'b010, 3'b101, 3'b000, 3'b010};
        logic [15:0] rf;
        logic rc, rz, rn;
        int lat;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                do_op(w, vm[i], vs[i], va[i], vb[i], vc[i], vu[i], 1'b1, rf, rc, rz, rn, lat);
                checks++;
                if (rf !== ef[i] || {rc, rz, rn} !== ecz[i]) begin
                    errors++;
                    $display("FAIL directed_%0d dut%0d: got f=%h czn=%b required f=%h czn=%b",
                             i, w, rf, {rc, rz, rn}, ef[i], ecz[i]);
                end
                checks++;
                if (lat !== ((w == 0) ? 4 : 1)) begin
                    errors++;
                    $display("FAIL latency dut%0d: got %0d required %0d", w, lat, (w == 0) ? 4 : 1);
                end
                flag_m[w] = ecz[i][2];
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] rf, aa, bb;
        logic [16:0] exp_v;
        logic rc, rz, rn, m, cin, ufc;
        logic [3:0] s;
        int lat, w;
        for (int i = 0; i < 80; i++) begin
            w   = i % 2;
            m   = 1'($urandom_range(0, 1));
            s   = 4'($urandom_range(0, 15));
            aa  = 16'($urandom);
            bb  = (i % 7 == 3) ? ~aa : ((i % 7 == 5) ? aa : 16'($urandom));
            cin = 1'($urandom_range(0, 1));
            ufc = ($urandom_range(0, 3) == 0);
            exp_v = ref_op(m, s, aa, bb, ufc ? flag_m[w] : cin);
            do_op(w, m, s, aa, bb, cin, ufc, 1'b1, rf, rc, rz, rn, lat);
            checks++;
            if (rf !== exp_v[15:0] || rc !== exp_v[16] || rz !== (exp_v[15:0] == 16'h0)
                || rn !== exp_v[15] || lat !== ((w == 0) ? 4 : 1)) begin
                errors++;
                $display("FAIL random_%0d dut%0d m=%b s=%h a=%h b=%h: got f=%h c=%b z=%b n=%b lat=%0d required f=%h c=%b",
                         i, w, m, s, aa, bb, rf, rc, rz, rn, lat, exp_v[15:0], exp_v[16]);
            end
            flag_m[w] = exp_v[16];
        end
    endtask

    task automatic test_hold;
        logic [15:0] rf;
        logic [16:0] exp_v;
        logic rc, rz, rn;
        int lat;
        exp_v = ref_op(1'b0, 4'd6, 16'h0003, 16'h0005, 1'b1);
        do_op(0, 1'b0, 4'd6, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, rf, rc, rz, rn, lat);
        flag_m[0] = exp_v[16];
        iv0 = 1'b1; a = 16'h7777; b = 16'h1111; sel = 4'd9; mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (f0 !== exp_v[15:0] || c0 !== exp_v[16] || n0 !== exp_v[15] || z0 !== 1'b0
                || ir0 !== 1'b0 || ov0 !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d: got f=%h c=%b ir=%b ov=%b required f=%h c=%b ir=0 ov=1",
                         k, f0, c0, ir0, ov0, exp_v[15:0], exp_v[16]);
            end
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or0 = 1'b0;
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || f0 !== exp_v[15:0]) begin
            errors++;
            $display("FAIL hold_release: got ir=%b ov=%b f=%h required ir=1 ov=0 f=%h",
                     ir0, ov0, f0, exp_v[15:0]);
        end
        mode = 1'bx; sel = 4'bxxxx;
        repeat (3) @(negedge clk);
        checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0 || ir1 !== 1'b1 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_x_inputs: got ir=%b%b ov=%b%b required 11 00", ir0, ir1, ov0, ov1);
        end
    endtask

    task automatic test_reset_midrun;
        logic [15:0] rf;
        logic rc, rz, rn;
        int lat;
        bit seen;
        @(negedge clk);
        mode = 1'b0; sel = 4'd9; a = 16'h1234; b = 16'h4321; carry_in = 1'b0; use_flag_carry = 1'b0;
        iv0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f0, c0, z0, n0, ov0} !== 20'h0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got %h required 0", {f0, c0, z0, n0, ov0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        flag_m[0] = 1'b0; flag_m[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ov0 || !ir0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_result: got out_valid/busy seen=%b required 0", seen);
        end
        for (int w = 0; w < 2; w++) begin
            do_op(w, 1'b0, 4'd9, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, rf, rc, rz, rn, lat);
            checks++;
            if (rf !== 16'h0000 || rz !== 1'b1 || rc !== 1'b0) begin
                errors++;
                $display("FAIL flag_cleared dut%0d: got f=%h z=%b c=%b required f=0000 z=1 c=0",
                         w, rf, rz, rc);
            end
        end
    endtask

    initial begin
        iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b0; or1 = 1'b0;
        mode = 1'b0; sel = 4'd0; a = 16'h0; b = 16'h0; carry_in = 1'b0; use_flag_carry = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
